// File: rtl/datamem_responder.sv
// Word-organised data memory behind valid/ready request and response channels,
// with WAIT_CYCLES wait states per access. Optional macro: DATAMEM_MISALIGN_CHECK_EN.
module datamem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_next_state;
  logic        r_req_ready;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_in_idle, w_accept, w_do_access, w_wr;
  logic          w_acc_we;
  logic [31:0]   w_acc_addr, w_acc_wdata;
  logic [3:0]    w_acc_be;
  logic [29:0]   w_word;
  logic [IW-1:0] w_idx;
  logic          w_oob, w_misalign, w_err;

  assign w_in_idle = (r_state == IDLE);
  assign w_accept  = w_in_idle && req_valid && r_req_ready;

  // With zero wait states the access happens at the accept edge, so it must see
  // the live request; otherwise it uses the copy latched at accept.
  assign w_acc_we    = w_in_idle ? req_we    : r_we;
  assign w_acc_addr  = w_in_idle ? req_addr  : r_addr;
  assign w_acc_wdata = w_in_idle ? req_wdata : r_wdata;
  assign w_acc_be    = w_in_idle ? req_be    : r_be;

  assign w_do_access = (w_accept && (WAIT_CYCLES == 0)) ||
                       ((r_state == WAIT) && (r_cnt == 4'd1));

  assign w_word = 30'((w_acc_addr - ADDR_BASE) >> 2);
  assign w_idx  = w_word[IW-1:0];
  assign w_oob  = (w_acc_addr < ADDR_BASE) || (w_word >= 30'(DEPTH_WORDS));

`ifdef DATAMEM_MISALIGN_CHECK_EN
  assign w_misalign = (w_acc_addr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = w_oob || w_misalign;
  assign w_wr  = w_do_access && w_acc_we && !w_err;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_accept)     w_next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (r_cnt == 4'd1) w_next_state = RESP;
      RESP: if (rsp_ready)    w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b0;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == IDLE);

      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
        r_cnt   <= WAIT_LD;
      end else if ((r_state == WAIT) && (r_cnt > 4'd1)) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (w_do_access) begin
        r_cnt <= 4'd0;
      end

      if (w_do_access) begin
        r_err   <= w_err;
        r_rdata <= (!w_acc_we && !w_err) ? r_mem[w_idx] : 32'd0;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset and only the control path is cleared.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_be[b]) r_mem[w_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_datamem_responder.sv
// Self-checking bench: instance A (2 wait states, base 0, 256 words) and instance B
// (0 wait states, base 0x1000, 16 words) checked against a byte-level memory model.
module tb_datamem_responder;

  logic        clk = 1'b0;
  logic        reset;
  int          sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_rdata_a, rsp_rdata_b;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  datamem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_BASE(32'h0000_0000)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && (sel == 0)), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
  );

  datamem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0), .ADDR_BASE(32'h0000_1000)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && (sel == 1)), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
  );

  assign req_ready = (sel == 1) ? req_ready_b : req_ready_a;
  assign rsp_valid = (sel == 1) ? rsp_valid_b : rsp_valid_a;
  assign rsp_rdata = (sel == 1) ? rsp_rdata_b : rsp_rdata_a;
  assign rsp_err   = (sel == 1) ? rsp_err_b   : rsp_err_a;

  // Reference memory: data plus a per-byte "written since time zero" mask.
  logic [31:0] m_mem   [2][256];
  logic [3:0]  m_known [2][256];

  function automatic logic [31:0] m_base(int s);
    return (s == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic longint m_depth(int s);
    return (s == 1) ? 16 : 256;
  endfunction

  function automatic int m_wait(int s);
    return (s == 1) ? 0 : 2;
  endfunction

  function automatic logic m_err(int s, logic [31:0] a);
    if (a < m_base(s)) return 1'b1;
    if (longint'((a - m_base(s)) >> 2) >= m_depth(s)) return 1'b1;
`ifdef DATAMEM_MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int m_idx(int s, logic [31:0] a);
    return int'((a - m_base(s)) >> 2);
  endfunction

  function automatic logic [31:0] byte_mask(logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
  endtask

  // Present a request and return just after the accepting edge, scrambling req_*.
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    int guard = 0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'(($urandom) & 1); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
  endtask

  // Counts cycles from the accept cycle (=1) until rsp_valid is seen at a falling edge.
  task automatic wait_rsp(output int n);
    n = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid || n > 40) break;
      n++;
    end
  endtask

  task automatic finish_rsp(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be, input int hold,
                            output logic [31:0] got_rdata, output logic got_err);
    int n;
    logic exp_err;
    logic [31:0] mask;
    int idx;
    wait_rsp(n);
    check({tag, "_latency"}, 32'(n), 32'(m_wait(sel) + 1));
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    exp_err   = m_err(sel, addr);
    idx       = m_idx(sel, addr);
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    if (we || exp_err) begin
      check({tag, "_rdata"}, got_rdata, 32'd0);
    end else begin
      mask = byte_mask(m_known[sel][idx]);
      if (mask != 32'd0) check({tag, "_rdata"}, got_rdata & mask, m_mem[sel][idx] & mask);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, got_rdata);
      check({tag, "_hold_err"},   32'(rsp_err), 32'(got_err));
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_post_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_post_err"},   32'(rsp_err), 32'd0);
    check({tag, "_post_req_ready"}, 32'(req_ready), 32'd1);
    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          m_mem[sel][idx][8*b +: 8] = wdata[8*b +: 8];
          m_known[sel][idx][b] = 1'b1;
        end
      end
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int hold,
                     output logic [31:0] got_rdata, output logic got_err);
    send_req(we, addr, wdata, be);
    finish_rsp(tag, we, addr, wdata, be, hold, got_rdata, got_err);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check_outputs_zero(tag);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) begin
        m_mem[s][i] = 32'd0; m_known[s][i] = 4'd0;
      end

    vt[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
    vt[4]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vt[5]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    vt[6]  = '{1'b1, 32'h00,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vt[7]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1};
    vt[8]  = '{1'b1, 32'h400, 32'h11111111, 4'hF, 32'h0,        1'b1};
    vt[9]  = '{1'b0, 32'h00,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
`ifdef DATAMEM_MISALIGN_CHECK_EN
    vt[10] = '{1'b0, 32'h12,  32'h0,        4'h0, 32'h0,        1'b1};
`else
    vt[10] = '{1'b0, 32'h12,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
`endif
    vt[11] = '{1'b1, 32'h20,  32'h55AA55AA, 4'hF, 32'h0,        1'b0};

    sel = 0; reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check_outputs_zero($sformatf("reset%0d", s));
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      txn($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, 0, rd, er);
      check($sformatf("vec%0d_tbl_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_tbl_err", i), 32'(er), 32'(vt[i].exp_err));
    end

    // Back-pressure: response held for 10 cycles.
    txn("backpressure", 1'b0, 32'h10, 32'h0, 4'h0, 10, rd, er);
    check("backpressure_rdata", rd, 32'hDEADBEAA);

    // Reset while a store waits: store must be dropped.
    send_req(1'b1, 32'h20, 32'h12345678, 4'hF);
    @(negedge clk);
    pulse_reset("rst_in_wait");
    txn("after_wait_reset", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er);
    check("after_wait_reset_old", rd, 32'h55AA55AA);

    // Reset while a response is pending: response discarded.
    send_req(1'b0, 32'h10, 32'h0, 4'h0);
    wait_rsp(n);
    check("rst_in_resp_latency", 32'(n), 32'd3);
    pulse_reset("rst_in_resp");

    // Zero-wait instance with a non-zero base.
    sel = 1;
    txn("b_store", 1'b1, 32'h1020, 32'h0BADF00D, 4'hF, 0, rd, er);
    txn("b_load", 1'b0, 32'h1020, 32'h0, 4'h0, 2, rd, er);
    check("b_load_tbl", rd, 32'h0BADF00D);
    txn("b_below_base", 1'b0, 32'h0FFC, 32'h0, 4'h0, 0, rd, er);
    check("b_below_base_tbl", 32'(er), 32'd1);
    txn("b_past_end", 1'b1, 32'h1040, 32'hFFFFFFFF, 4'hF, 0, rd, er);
    check("b_past_end_tbl", 32'(er), 32'd1);

    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [31:0] addr;
      int          word;
      sel  = int'($urandom_range(0, 1));
      word = ($urandom_range(0, 7) == 0) ? int'(m_depth(sel)) + int'($urandom_range(0, 3))
                                         : int'($urandom_range(0, 15));
      addr = m_base(sel) + 32'(word * 4);
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      if (sel == 1 && $urandom_range(0, 9) == 0) addr = m_base(1) - 32'(4 * $urandom_range(1, 4));
      we = 1'($urandom_range(0, 1));
      txn($sformatf("rand%0d", i), we, addr, $urandom, 4'($urandom), int'($urandom_range(0, 2)),
          rd, er);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/datamem_responder.md
Name: datamem_responder

Overview:
- Slave-side data memory that answers load/store requests from the core over a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait states per access, which lets the team move the core off its zero-latency combinational data memory.
- Holds a word-organised RAM with byte-enable writes.
- Flags out-of-range accesses with an error bit.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM (power of two, at least 4).
- WAIT_CYCLES, 2, wait states between request accept and memory access (0..15).
- ADDR_BASE, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i covers byte lane [8i+7:8i]; ignored on loads.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errored accesses.
- rsp_err  output  1  access was rejected.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (reset).
- While reset is high: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
- req_ready goes to 1 on the first clk edge after reset deasserts.
- RAM contents are not cleared by reset. The bench must write before it reads.
- FSM states are IDLE, WAIT and RESP.
- req_ready = 1 only in IDLE. It is a registered state decode with no combinational path from any input.
- IDLE:
  - Accept happens when req_valid && req_ready at a rising edge.
  - On accept, latch req_we, req_addr, req_wdata and req_be, and load cnt = WAIT_CYCLES.
  - If WAIT_CYCLES == 0, perform the access at the accept edge and go to RESP. Otherwise go to WAIT.
- WAIT:
  - If cnt > 1, decrement cnt each cycle.
  - When cnt == 1, perform the access at that edge and go to RESP.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accept edge.
- Access:
  - Word index = (addr - ADDR_BASE) >> 2, using 32-bit unsigned subtraction.
  - Out of range when addr < ADDR_BASE or index >= DEPTH_WORDS. Out of range means no RAM change, rsp_err = 1, rsp_rdata = 0.
  - Store: write only the byte lanes whose req_be bit is 1; rsp_rdata = 0. be = 4'b0000 is a legal no-op store with rsp_err = 0.
  - Load: rsp_rdata = full word at the index.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err stay stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE, clear rsp_valid, and zero rsp_rdata and rsp_err.
  - No new request is accepted in the handshake cycle. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles minimum.
- Back-pressure: rsp_ready may stay low indefinitely. The responder holds RESP with no timeout.
- Request stability: req_* changes after accept have no effect, because the values are already latched.
- Reset during an access: if reset asserts in WAIT, the pending store is dropped and the RAM is unchanged. If reset asserts in RESP, the response is discarded.
- Read-after-write: a load accepted after a store's response completes returns the new data.

Optional Feature:
- Macro: DATAMEM_MISALIGN_CHECK_EN.
- Defined: an access with req_addr[1:0] != 2'b00 is an error. rsp_err = 1, no RAM change, rsp_rdata = 0. Latency and handshake are unchanged.
- Undefined: req_addr[1:0] is ignored and the access goes to the containing word. rsp_err reflects range checking only.

Test Plan:
- Reset, then store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid rises 3 cycles after each accept (WAIT_CYCLES = 2).
- Store 0x10 with wdata 0x000000AA, be 4'b0001, then load 0x10 -> 0xDEADBEAA. Store with be 4'b0000 -> rsp_err = 0 and the word is unchanged.
- Load addr 0x400 (index 256, DEPTH_WORDS = 256) -> rsp_err = 1, rsp_rdata = 0. A store to 0x400 -> rsp_err = 1, and word 0 is not aliased.
- Hold rsp_ready low for 10 cycles after a load of 0x10 -> rsp_valid stays 1, rsp_rdata stays 0xDEADBEAA, req_ready stays 0. Release -> IDLE, req_ready = 1 on the next cycle.
- Accept store 0x20 = 0x12345678, then assert reset during WAIT -> all outputs 0. After reset, load 0x20 returns the previous contents, not 0x12345678. Repeat with WAIT_CYCLES = 0 -> response 1 cycle after accept.
- Load 0x12: with DATAMEM_MISALIGN_CHECK_EN defined -> rsp_err = 1, rdata = 0. Without it -> rsp_err = 0, rdata = word at 0x10.
